regbank_read_port: RTL and testbench
====================================

REGBANK_READ_PORT -- requirements
Module: regbank_read_port

Interface
REQ-001 The module SHALL have parameter W, default 32, data width of each register.
REQ-002 The module SHALL have parameter NREG, default 32, number of registers; the address width is log2(NREG).
REQ-003 The module SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  read request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- rs1_addr, rs2_addr  in  5 each  source register indices.
- rd_alloc  in  1  request reserves destination rd_addr.
- rd_addr  in  5  destination to mark busy.
- ReadData  in  NREG x W  register bank outputs; ReadData[0] is always 0.
- wb_valid  in  1  writeback commits this cycle.
- wb_addr  in  5  writeback destination.
- wb_data  in  W  writeback value, same value the bank latches this edge.
- rsp_valid  out  1  operands available.
- rsp_ready  in  1  consumer takes operands.
- rs1_data, rs2_data  out  W each  operand values.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

Function
REQ-004 The module SHALL hold a busy[NREG] scoreboard; busy[0] SHALL be constant 0.
REQ-005 The hazard condition SHALL be: busy[rs1_addr] or busy[rs2_addr] is set, and the busy register is not cleared by the current-cycle writeback (wb_valid && wb_addr matches).
REQ-006 The output stage SHALL be a two-state FSM, EMPTY and FULL. EMPTY->FULL on accept. FULL->EMPTY on rsp_ready without accept. FULL stays FULL on rsp_ready with accept, or without rsp_ready.
REQ-007 The ready condition SHALL be req_ready = (EMPTY or rsp_ready) and not hazard.
REQ-008 On accept (req_valid && req_ready) in cycle N, rs1_data/rs2_data SHALL be registered and rsp_valid SHALL be 1 in cycle N+1: one-cycle latency.
REQ-009 The operand source SHALL be wb_data when wb_valid, wb_addr == rsN_addr and rsN_addr != 0 (bypass); otherwise ReadData[rsN_addr].
REQ-010 While FULL and rsp_ready is 0, rsp_valid, rs1_data and rs2_data SHALL be held stable.
REQ-011 On accept with rd_alloc=1 and rd_addr != 0, busy[rd_addr] SHALL be set at the next edge; rd_alloc with rd_addr == 0 SHALL have no effect.
REQ-012 wb_valid SHALL clear busy[wb_addr] at the next edge; if the same register is cleared and allocated in the same cycle, set SHALL win.
REQ-013 A request SHALL be able to read a register and also allocate it; operands SHALL use the pre-allocation value.
REQ-014 stall_cnt SHALL increment each cycle where req_valid && hazard, and SHALL saturate at 16'hFFFF.
REQ-015 wb_valid to a non-busy register SHALL be legal; it clears nothing and still bypasses.

Reset
REQ-016 When rst_n is low, the module SHALL asynchronously clear busy, set the FSM to EMPTY, and force rsp_valid=0, rs1_data=0, rs2_data=0 and stall_cnt=0.
REQ-017 A request in flight at reset SHALL be dropped; no response SHALL follow reset release.

Configuration
REQ-018 Macro REGBANK_READ_BYPASS_EN SHALL control forwarding. Defined: REQ-005 and REQ-009 apply as written. Undefined: no wb_data forwarding; a same-cycle writeback to a busy source still counts as hazard, so the request stalls one cycle and reads ReadData afterwards.

Structure
REQ-019 The shared package regbank_pkg SHALL hold W, NREG, the address width constant, and the FSM state enum (EMPTY, FULL).
REQ-020 The scoreboard SHALL be a sub-module regbank_scoreboard with set/clear/query ports; operand select and the FSM SHALL stay in the top module.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Reset, then request rs1=3, rs2=0 with ReadData[3]=32'hA5A5_0001 -> rsp_valid next cycle, rs1_data=32'hA5A5_0001, rs2_data=0.
- Allocate rd=7, then request rs1=7 -> req_ready=0, stall_cnt increments per cycle; wb_valid wb_addr=7 wb_data=32'h1234 -> with bypass accepted that cycle with rs1_data=32'h1234; without bypass accepted one cycle later with the same value.
- rsp_ready=0 for 4 cycles while FULL -> outputs stable, req_ready=0; then rsp_ready=1 with a new request -> back-to-back accept, no bubble.
- Same-cycle wb_addr=5 and allocation of rd=5 -> busy[5]=1 afterwards; a request on rs1=5 stalls.
- rd_alloc with rd_addr=0, then request rs1=0 -> no stall, rs1_data=0.
- rst_n low mid-FULL with busy bits set -> rsp_valid=0, all busy clear, stall_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared constants and output-stage state type for the register-bank read port.
package regbank_pkg;

  localparam int W    = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/regbank_scoreboard.sv
// Busy-bit scoreboard: one pending-writeback flag per register, entry 0 never busy.
module regbank_scoreboard #(
  parameter int NREG = regbank_pkg::NREG
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    set_en,
  input  logic [$clog2(NREG)-1:0] set_addr,
  input  logic                    clr_en,
  input  logic [$clog2(NREG)-1:0] clr_addr,
  input  logic [$clog2(NREG)-1:0] qa_addr,
  input  logic [$clog2(NREG)-1:0] qb_addr,
  output logic                    qa_busy,
  output logic                    qb_busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Set is applied after clear so a same-cycle allocate wins over writeback.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign qa_busy = busy_q[qa_addr];
  assign qb_busy = busy_q[qb_addr];

endmodule

// File: rtl/regbank_read_port.sv
// Operand read port with RAW hazard stall and a one-entry output register.
// REGBANK_READ_BYPASS_EN: forward same-cycle writeback data to the operands.
//
// state | meaning
// EMPTY | no operands held, rsp_valid low
// FULL  | operands held until the consumer takes them
import regbank_pkg::*;

module regbank_read_port #(
  parameter int W    = regbank_pkg::W,
  parameter int NREG = regbank_pkg::NREG
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(NREG)-1:0]      rs1_addr,
  input  logic [$clog2(NREG)-1:0]      rs2_addr,
  input  logic                         rd_alloc,
  input  logic [$clog2(NREG)-1:0]      rd_addr,
  input  logic [NREG-1:0][W-1:0]       ReadData,
  input  logic                         wb_valid,
  input  logic [$clog2(NREG)-1:0]      wb_addr,
  input  logic [W-1:0]                 wb_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [W-1:0]                 rs1_data,
  output logic [W-1:0]                 rs2_data,
  output logic [15:0]                  stall_cnt
);

  out_state_e  state_q, state_d;
  logic [W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [15:0]  stall_cnt_q, stall_cnt_d;
  logic [W-1:0] op1, op2;
  logic         busy1, busy2, hazard, accept, alloc_en;

  regbank_scoreboard #(.NREG(NREG)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (alloc_en),
    .set_addr (rd_addr),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .qa_addr  (rs1_addr),
    .qb_addr  (rs2_addr),
    .qa_busy  (busy1),
    .qb_busy  (busy2)
  );

`ifdef REGBANK_READ_BYPASS_EN
  logic wb_hit1, wb_hit2;
  assign wb_hit1 = wb_valid && (wb_addr == rs1_addr);
  assign wb_hit2 = wb_valid && (wb_addr == rs2_addr);
  assign hazard  = (busy1 && !wb_hit1) || (busy2 && !wb_hit2);
  assign op1     = (wb_hit1 && rs1_addr != '0) ? wb_data : ReadData[rs1_addr];
  assign op2     = (wb_hit2 && rs2_addr != '0) ? wb_data : ReadData[rs2_addr];
`else
  // Without forwarding the request waits until the bank holds the new value.
  logic wb_data_unused;
  assign wb_data_unused = ^wb_data;
  assign hazard = busy1 || busy2;
  assign op1    = ReadData[rs1_addr];
  assign op2    = ReadData[rs2_addr];
`endif

  assign req_ready = ((state_q == EMPTY) || rsp_ready) && !hazard;
  assign accept    = req_valid && req_ready;
  assign alloc_en  = accept && rd_alloc && (rd_addr != '0);

  always_comb begin
    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (rsp_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      rs1_d = op1;
      rs2_d = op2;
    end
    if (req_valid && hazard && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      rs1_q       <= '0;
      rs2_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rs1_data  = rs1_q;
  assign rs2_data  = rs2_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_regbank_read_port.sv
// Scoreboard bench for regbank_read_port: directed scenarios plus random traffic.
module tb_regbank_read_port;
  localparam int TW = 32;
  localparam int TN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            req_valid, req_ready, rd_alloc, wb_valid, rsp_valid, rsp_ready;
  logic [4:0]      rs1_addr, rs2_addr, rd_addr, wb_addr;
  logic [TW-1:0]   wb_data, rs1_data, rs2_data;
  logic [15:0]     stall_cnt;
  logic [TN-1:0][TW-1:0] read_data;

  logic [TW-1:0] mem [TN];
  bit            mbusy [TN];
  logic [15:0]   mstall;

  typedef struct { logic [TW-1:0] d1; logic [TW-1:0] d2; } rsp_t;
  rsp_t exp_q [$];

  int n_vec = 0;
  int n_err = 0;

  always_comb for (int i = 0; i < TN; i++) read_data[i] = mem[i];

  regbank_read_port #(.W(TW), .NREG(TN)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_alloc(rd_alloc), .rd_addr(rd_addr),
    .ReadData(read_data), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the output register is valid it must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0 at %0t", $time);
        end else begin
          chk("rs1_data", rs1_data, exp_q[0].d1);
          chk("rs2_data", rs2_data, exp_q[0].d2);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        n_vec++; n_err++;
        $display("FAIL rsp_missing: got rsp_valid=0 expected 1 at %0t", $time);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic set_req(input bit v, input int r1, input int r2, input bit al, input int rd);
    req_valid = v; rs1_addr = 5'(r1); rs2_addr = 5'(r2); rd_alloc = al; rd_addr = 5'(rd);
  endtask

  task automatic set_wb(input bit v, input int a, input logic [31:0] d);
    wb_valid = v; wb_addr = 5'(a); wb_data = d;
  endtask

  // One clock cycle: reference model predicts readiness from the architectural rules.
  task automatic step(output bit acc);
    bit b1, b2, h1, h2, hz, rdy;
    logic [31:0] e1, e2;
    rsp_t r;
    @(negedge clk); #1;
    b1 = (rs1_addr != 0) && mbusy[rs1_addr];
    b2 = (rs2_addr != 0) && mbusy[rs2_addr];
    h1 = wb_valid && (wb_addr == rs1_addr);
    h2 = wb_valid && (wb_addr == rs2_addr);
`ifdef REGBANK_READ_BYPASS_EN
    hz = (b1 && !h1) || (b2 && !h2);
    e1 = (h1 && rs1_addr != 0) ? wb_data : mem[rs1_addr];
    e2 = (h2 && rs2_addr != 0) ? wb_data : mem[rs2_addr];
`else
    hz = b1 || b2;
    e1 = mem[rs1_addr];
    e2 = mem[rs2_addr];
`endif
    rdy = ((exp_q.size() == 0) || rsp_ready) && !hz;
    chk("req_ready", req_ready, rdy);
    chk("stall_cnt", stall_cnt, mstall);
    acc = req_valid && rdy;
    @(posedge clk);
    if (req_valid && hz && mstall != 16'hFFFF) mstall++;
    if (wb_valid) begin
      mbusy[wb_addr] = 0;
      if (wb_addr != 0) mem[wb_addr] <= wb_data;
    end
    if (acc) begin
      if (rd_alloc && rd_addr != 0) mbusy[rd_addr] = 1;
      r.d1 = e1; r.d2 = e2;
      exp_q.push_back(r);
    end
    #1;
  endtask

  task automatic until_acc(input string name, output int n);
    bit acc;
    n = 0;
    acc = 0;
    while (!acc && n < 20) begin
      step(acc);
      n++;
      wb_valid = 0;
    end
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got no accept expected accept within 20 cycles", name);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish by 400us");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    logic [31:0] d;
    for (int i = 0; i < TN; i++) begin
      mem[i] <= (i == 0) ? 32'h0 : $urandom;
      mbusy[i] = 0;
    end
    mstall = 0;
    set_req(0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    rsp_ready = 1;
    #2;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rs1", rs1_data, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_req_ready", req_ready, 1);
    #10 rst_n = 1;
    @(posedge clk); #1;

    // Basic read with rs2 = x0
    mem[3] <= 32'hA5A5_0001;
    set_req(1, 3, 0, 0, 0);
    step(acc); chk("s1_acc", acc, 1);
    set_req(0, 0, 0, 0, 0);
    #1; chk("s1_rsp_valid", rsp_valid, 1);
    chk("s1_rs1", rs1_data, 32'hA5A5_0001);
    chk("s1_rs2", rs2_data, 0);
    step(acc);

    // RAW hazard on x7 resolved by writeback
    set_req(1, 0, 0, 1, 7);
    step(acc); chk("s2_alloc", acc, 1);
    set_req(1, 7, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(acc); chk("s2_stall", acc, 0);
    end
    set_wb(1, 7, 32'h1234);
    step(acc);
    set_wb(0, 0, 0);
`ifdef REGBANK_READ_BYPASS_EN
    chk("s2_bypass_acc", acc, 1);
`else
    chk("s2_wb_cycle_acc", acc, 0);
    step(acc); chk("s2_late_acc", acc, 1);
`endif
    set_req(0, 0, 0, 0, 0);
    #1; chk("s2_rs1", rs1_data, 32'h1234);
    step(acc);

    // Backpressure hold then back-to-back accept
    set_req(1, 1, 2, 0, 0);
    step(acc); chk("s3_first", acc, 1);
    rsp_ready = 0;
    set_req(1, 3, 4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(acc); chk("s3_hold", acc, 0);
    end
    rsp_ready = 1;
    step(acc); chk("s3_b2b_a", acc, 1);
    set_req(1, 5, 6, 0, 0);
    step(acc); chk("s3_b2b_b", acc, 1);
    set_req(0, 0, 0, 0, 0);
    step(acc);

    // Same-cycle clear and allocate of x5: set wins
    set_req(1, 0, 0, 1, 5);
    set_wb(1, 5, $urandom);
    step(acc); chk("s4_alloc", acc, 1);
    set_wb(0, 0, 0);
    set_req(1, 5, 0, 0, 0);
    step(acc); chk("s4_stall", acc, 0);
    set_wb(1, 5, 32'hCAFE_0005);
    until_acc("s4", n);
    set_req(0, 0, 0, 0, 0);
    step(acc);

    // Allocating x0 has no effect
    set_req(1, 0, 0, 1, 0);
    step(acc); chk("s5_alloc", acc, 1);
    set_req(1, 0, 0, 0, 0);
    step(acc); chk("s5_acc", acc, 1);
    set_req(0, 0, 0, 0, 0);
    #1; chk("s5_rs1", rs1_data, 0);
    step(acc);

    // Asynchronous reset while FULL with busy registers
    set_req(1, 0, 0, 1, 9);  step(acc);
    set_req(1, 0, 0, 1, 10); step(acc);
    rsp_ready = 0;
    set_req(1, 9, 0, 0, 0);  step(acc);
    set_req(1, 9, 10, 0, 0); step(acc);
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_rs1", rs1_data, 0);
    chk("ar_rs2", rs2_data, 0);
    chk("ar_stall", stall_cnt, 0);
    chk("ar_busy_clear", req_ready, 1);
    exp_q.delete();
    for (int i = 0; i < TN; i++) mbusy[i] = 0;
    mstall = 0;
    set_req(0, 0, 0, 0, 0);
    rsp_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("ar_no_rsp", rsp_valid, 0);
    step(acc); step(acc);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_req($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 2) == 0, $urandom_range(0, 7));
      d = $urandom;
      set_wb($urandom_range(0, 2) == 0, $urandom_range(0, 7), d);
      rsp_ready = $urandom_range(0, 3) != 0;
      step(acc);
    end
    set_req(0, 0, 0, 0, 0);
    set_wb(0, 0, 0);
    rsp_ready = 1;
    step(acc); step(acc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
